// File: rtl/swap_request_sequencer.sv
// swap_request_sequencer
//
// Queues swap requests (pairs of register-file addresses) and plays them out
// one at a time to a register file that needs SWAP_CYCLES cycles per swap.
// Each request is popped into address_A/address_B, a one-cycle swap command
// is issued, the sequencer waits out the register-file latency while holding
// off the write source, then pulses done. Requests whose two addresses are
// equal retire immediately with no swap.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is "queue not full" and depends only on
// registered state, never on req_valid or on a pop in the same cycle.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   req_valid    in   request presented
//   req_a/req_b  in   [ADDR_WIDTH] the two locations to swap
//   req_ready    out  queue can accept a request
//   address_A/B  out  [ADDR_WIDTH] locations driven to the register file
//   swap         out  one-cycle swap command
//   write_hold   out  write source must not assert we
//   done         out  one-cycle pulse when a request retires
//   busy         out  queue non-empty or state machine not idle
//   swap_count   out  [8] executed swaps, saturating at 255
//   fsm_state_o  out  [2] current state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)

module swap_request_sequencer #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_a,
    input  logic [ADDR_WIDTH-1:0] req_b,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] address_A,
    output logic [ADDR_WIDTH-1:0] address_B,
    output logic                  swap,
    output logic                  write_hold,
    output logic                  done,
    output logic                  busy,
    output logic [7:0]            swap_count,
    output logic [1:0]            fsm_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(SWAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ---------------- request queue ----------------
    logic [2*ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          count_q;
    logic                    full, empty, push, pop;
    logic [ADDR_WIDTH-1:0]   head_a, head_b;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = req_valid && !full;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reset empties the queue through count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_a, req_b};
    end

    assign head_a = mem_q[rd_ptr_q][2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign head_b = mem_q[rd_ptr_q][ADDR_WIDTH-1:0];

    // ---------------- state machine ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
    logic [7:0]       swap_count_q;

    assign pop = (state_q == IDLE) && !empty;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                // A request naming the same location twice needs no swap.
                if (!empty) state_d = (head_a == head_b) ? DONE : ISSUE;
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
            WAIT: begin
                if (wait_cnt_q == '0) state_d = DONE;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            swap_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (pop) begin
                addr_a_q <= head_a;
                addr_b_q <= head_b;
            end
            // Counted as the swap command leaves ISSUE; sticks at 255.
            if (state_q == ISSUE && swap_count_q != 8'hFF)
                swap_count_q <= swap_count_q + 8'd1;
        end
    end

    // All outputs decode registered state, so reset clears them at once.
    assign req_ready   = !full;
    assign address_A   = addr_a_q;
    assign address_B   = addr_b_q;
    assign swap        = (state_q == ISSUE);
    assign write_hold  = (state_q == ISSUE) || (state_q == WAIT);
    assign done        = (state_q == DONE);
    assign busy        = !empty || (state_q != IDLE);
    assign swap_count  = swap_count_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_swap_request_sequencer.sv
// Self-checking bench for swap_request_sequencer. A transaction-level model
// (request queue plus a per-cycle schedule of swap/wait/done cycles for the
// job in progress) predicts every output each cycle; a retire scoreboard
// checks completion order; directed checks cover latency and boundaries.

module tb_swap_request_sequencer;

    localparam int AW     = 7;
    localparam int DEPTH  = 4;
    localparam int SC     = 3;
    localparam int S_SWAP = 1;
    localparam int S_WAIT = 2;
    localparam int S_DONE = 3;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic [AW-1:0] req_a, req_b;
    logic          req_ready;
    logic [AW-1:0] address_A, address_B;
    logic          swap, write_hold, done, busy;
    logic [7:0]    swap_count;
    logic [1:0]    fsm_state;

    swap_request_sequencer #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .SWAP_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .address_A  (address_A),
        .address_B  (address_B),
        .swap       (swap),
        .write_hold (write_hold),
        .done       (done),
        .busy       (busy),
        .swap_count (swap_count),
        .fsm_state_o(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    // ---------------- model and scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } req_t;

    int            vectors = 0;
    int            errors  = 0;
    int            cyc     = 0;
    req_t          m_q[$];
    int            m_sched[$];
    logic [AW-1:0] m_addr_a, m_addr_b;
    int            m_cnt;
    bit            m_acc;
    logic [2*AW-1:0] exp_q[$];
    int            swaps_since_done;
    int            swaps_seen;
    int            swap_edge, done_edge, hold_cycles;

    function automatic void check(input string tag, input logic [31:0] obs,
                                  input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_sched.delete();
        exp_q.delete();
        m_addr_a = '0;
        m_addr_b = '0;
        m_cnt = 0;
        m_acc = 1'b0;
        swaps_since_done = 0;
    endfunction

    // One rising edge: retire the cycle just finished, start a job if idle,
    // then take the presented request if there was room before the edge.
    function automatic void model_edge(input logic v, input logic [AW-1:0] a,
                                       input logic [AW-1:0] b);
        bit   room;
        int   cur;
        req_t h;
        room  = (m_q.size() < DEPTH);
        m_acc = v && room;
        if (m_sched.size() != 0) begin
            cur = m_sched.pop_front();
            if (cur == S_SWAP && m_cnt < 255) m_cnt++;
        end else if (m_q.size() != 0) begin
            h = m_q.pop_front();
            m_addr_a = h.a;
            m_addr_b = h.b;
            if (h.a != h.b) begin
                m_sched.push_back(S_SWAP);
                for (int i = 0; i < SC; i++) m_sched.push_back(S_WAIT);
            end
            m_sched.push_back(S_DONE);
        end
        if (m_acc) begin
            m_q.push_back({a, b});
            exp_q.push_back({a, b});
        end
    endfunction

    task automatic check_outputs();
        bit m_swap, m_hold, m_done;
        logic [2*AW-1:0] e;
        m_swap = (m_sched.size() != 0) && (m_sched[0] == S_SWAP);
        m_hold = (m_sched.size() != 0) && (m_sched[0] == S_SWAP || m_sched[0] == S_WAIT);
        m_done = (m_sched.size() != 0) && (m_sched[0] == S_DONE);
        check("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
        check("swap", 32'(swap), 32'(m_swap));
        check("write_hold", 32'(write_hold), 32'(m_hold));
        check("done", 32'(done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_q.size() != 0 || m_sched.size() != 0));
        check("address_A", 32'(address_A), 32'(m_addr_a));
        check("address_B", 32'(address_B), 32'(m_addr_b));
        check("swap_count", 32'(swap_count), 32'(m_cnt));
        if (swap) begin
            swaps_since_done++;
            swaps_seen++;
        end
        if (done) begin
            check("done_has_request", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("retire_order", 32'({address_A, address_B}), 32'(e));
                check("swaps_per_done", 32'(swaps_since_done),
                      32'(e[2*AW-1:AW] != e[AW-1:0]));
            end
            swaps_since_done = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b);
        req_valid = v;
        req_a = a;
        req_b = b;
        @(posedge clk);
        cyc++;
        model_edge(v, a, b);
        #1;
        req_valid = 1'b0;
        check_outputs();
        if (swap && swap_edge < 0) swap_edge = cyc;
        if (done && done_edge < 0) done_edge = cyc;
        if (write_hold) hold_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, req_a, req_b);
    endtask

    task automatic push_hold(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             output int steps);
        steps = 0;
        do begin
            step(1'b1, a, b);
            steps++;
        end while (!m_acc && steps < 64);
        check("push_accepted", 32'(m_acc), 32'd1);
    endtask

    task automatic wait_swap();
        int n;
        n = 0;
        while (!swap && n < 50) begin
            step(1'b0, req_a, req_b);
            n++;
        end
        check("wait_swap_seen", 32'(swap), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1'b0, req_a, req_b);
            n++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Asserts reset between edges, checks the outputs clear immediately,
    // holds it across one edge and releases it just after that edge.
    task automatic async_reset();
        #2;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_swap", 32'(swap), 32'd0);
        check("rst_write_hold", 32'(write_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_address_A", 32'(address_A), 32'd0);
        check("rst_address_B", 32'(address_B), 32'd0);
        check("rst_swap_count", 32'(swap_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int ns, k, done_after;
        logic [AW-1:0] ra, rb;

        reset = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        swap_edge = -1;
        done_edge = -1;
        hold_cycles = 0;
        swaps_seen = 0;
        model_reset();
        @(posedge clk);
        #1;
        async_reset();

        // Single request: latency, hold window, addresses, count.
        swap_edge = -1; done_edge = -1; hold_cycles = 0;
        push_hold(7'd22, 7'd28, ns);
        k = cyc;
        idle(8);
        check("lat_swap_edge", 32'(swap_edge), 32'(k + 1));
        check("lat_done_edge", 32'(done_edge), 32'(k + 2 + SC));
        check("lat_hold_cycles", 32'(hold_cycles), 32'(SC + 1));
        check("lat_address_A", 32'(address_A), 32'd22);
        check("lat_address_B", 32'(address_B), 32'd28);
        check("lat_swap_count", 32'(swap_count), 32'd1);

        // Equal addresses: retire with no swap.
        swap_edge = -1; done_edge = -1;
        push_hold(7'd9, 7'd9, ns);
        k = cyc;
        idle(4);
        check("eq_done_edge", 32'(done_edge), 32'(k + 1));
        check("eq_no_swap", 32'(swap_edge), 32'hFFFF_FFFF);
        check("eq_swap_count", 32'(swap_count), 32'd1);

        // Fill while a swap is in flight; the fifth waits for a pop and is
        // refused on the pop edge itself because the queue was full.
        push_hold(7'd1, 7'd2, ns);
        wait_swap();
        for (int i = 0; i < 4; i++) push_hold(AW'(10 + i), AW'(40 + i), ns);
        check("full_ready_low", 32'(req_ready), 32'd0);
        push_hold(7'd14, 7'd44, ns);
        check("full_fifth_wait_steps", 32'(ns), 32'd3);
        drain(100);

        // Push and pop on the same edge with DEPTH-1 entries queued.
        push_hold(7'd3, 7'd4, ns);
        wait_swap();
        for (int i = 0; i < DEPTH - 1; i++) push_hold(AW'(60 + i), AW'(90 + i), ns);
        idle(2);
        check("pp_ready_before", 32'(req_ready), 32'd1);
        push_hold(7'd70, 7'd100, ns);
        check("pp_same_edge", 32'(ns), 32'd1);
        check("pp_ready_after", 32'(req_ready), 32'd1);
        check("pp_issue_next", 32'(swap), 32'd1);
        drain(100);

        // Reset during WAIT with two requests queued.
        push_hold(7'd5, 7'd6, ns);
        wait_swap();
        push_hold(7'd20, 7'd21, ns);
        push_hold(7'd30, 7'd31, ns);
        check("mid_in_wait", 32'(write_hold && !swap), 32'd1);
        async_reset();
        done_after = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, req_a, req_b);
            if (done) done_after++;
        end
        check("mid_no_done", 32'(done_after), 32'd0);
        check("mid_swap_count", 32'(swap_count), 32'd0);

        // Random traffic, including some equal-address requests.
        for (int i = 0; i < 400; i++) begin
            ra = AW'($urandom_range(0, 127));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 127));
            step(1'($urandom_range(0, 1)), ra, rb);
        end
        drain(200);

        // 300 executed swaps: the counter must stick at 255.
        swaps_seen = 0;
        for (int i = 0; i < 300; i++) begin
            ra = AW'($urandom_range(0, 127));
            rb = ra ^ AW'($urandom_range(1, 127));
            push_hold(ra, rb, ns);
        end
        drain(200);
        check("sat_swap_pulses", 32'(swaps_seen), 32'd300);
        check("sat_swap_count", 32'(swap_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
